// File: rtl/block_ram_mp.sv
// Multi-read-port block RAM: one byte-enabled write port, NrReadPorts synchronous read ports
// with write bypass, and a clear sequencer. Define BLOCK_RAM_MP_OUTREG_EN for a 2-stage read.
module block_ram_mp #(
   parameter int unsigned          DataBits    = 32,
   parameter int unsigned          NrEntries   = 32,
   parameter int unsigned          NrReadPorts = 2,
   parameter logic [DataBits-1:0]  ClearValue  = '0,
   localparam int unsigned         AddrBits    = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_req_i,
   output logic                            busy_o,
   input  logic [NrReadPorts*AddrBits-1:0] rd_addr_i,
   output logic [NrReadPorts*DataBits-1:0] rd_data_o,
   input  logic                            wr_en_i,
   input  logic [AddrBits-1:0]             wr_addr_i,
   input  logic [DataBits/8-1:0]           wr_be_i,
   input  logic [DataBits-1:0]             wr_data_i
);

   localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NrEntries - 1);

   typedef enum logic {StIdle, StClear} state_e;

   state_e              state_q, state_d;
   logic [AddrBits-1:0] cnt_q, cnt_d;
   logic [DataBits-1:0] mem_q [NrEntries];
   logic [DataBits-1:0] wr_old, wr_merged;
   logic                clearing, wr_ok;

   assign clearing = (state_q == StClear);
   assign busy_o   = clearing;
   assign wr_ok    = !clearing && wr_en_i && (32'(wr_addr_i) < NrEntries);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (clear_req_i) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            if (cnt_q == LastAddr) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Merged word is the post-write contents; shared by the array write and every bypass path.
   always_comb begin
      wr_old    = mem_q[wr_addr_i];
      wr_merged = wr_old;
      for (int unsigned b = 0; b < DataBits / 8; b++) begin
         if (wr_be_i[b]) wr_merged[8*b +: 8] = wr_data_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (clearing) begin
         mem_q[cnt_q] <= ClearValue;
      end else if (wr_ok) begin
         mem_q[wr_addr_i] <= wr_merged;
      end
   end

   for (genvar p = 0; p < NrReadPorts; p++) begin : g_port
      logic [AddrBits-1:0] addr;
      logic [DataBits-1:0] rd_d, rd_q;

      assign addr = rd_addr_i[p*AddrBits +: AddrBits];

      always_comb begin
         rd_d = ClearValue;
         if (!clearing && (32'(addr) < NrEntries)) begin
            rd_d = (wr_ok && (addr == wr_addr_i)) ? wr_merged : mem_q[addr];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rd_q <= ClearValue;
         end else begin
            rd_q <= rd_d;
         end
      end

`ifdef BLOCK_RAM_MP_OUTREG_EN
      logic [DataBits-1:0] rd2_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rd2_q <= ClearValue;
         end else begin
            rd2_q <= rd_q;
         end
      end

      assign rd_data_o[p*DataBits +: DataBits] = rd2_q;
`else
      assign rd_data_o[p*DataBits +: DataBits] = rd_q;
`endif
   end

endmodule

// File: tb/tb_block_ram_mp.sv
// Self-checking bench for block_ram_mp: vector table, clear/reset sequences and random traffic
// compared against a word-array reference model.
module tb_block_ram_mp;

   localparam int unsigned DW = 32;
   localparam int unsigned NE = 24;
   localparam int unsigned NP = 2;
   localparam int unsigned AW = 5;
   localparam logic [31:0] CV = 32'hDEADBEEF;
`ifdef BLOCK_RAM_MP_OUTREG_EN
   localparam int Lat = 2;
`else
   localparam int Lat = 1;
`endif

   logic              clk, rst_n, clear_req, busy, wr_en;
   logic [NP*AW-1:0]  rd_addr;
   logic [NP*DW-1:0]  rd_data;
   logic [AW-1:0]     wr_addr, ra0, ra1;
   logic [DW/8-1:0]   wr_be;
   logic [DW-1:0]     wr_data;

   int checks = 0;
   int errors = 0;

   assign rd_addr = {ra1, ra0};

   block_ram_mp #(
      .DataBits   (DW),
      .NrEntries  (NE),
      .NrReadPorts(NP),
      .ClearValue (CV)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clear_req_i(clear_req),
      .busy_o     (busy),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_be_i    (wr_be),
      .wr_data_i  (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: word array, remaining clear cycles, and the expected read pipeline.
   logic [31:0] mm [NE];
   int          clr_left;
   logic [31:0] exp1 [NP];
   logic [31:0] exp2 [NP];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      clr_left = NE;
      for (int p = 0; p < NP; p++) begin
         exp1[p] = CV;
         exp2[p] = CV;
      end
   endtask

   task automatic model_edge();
      logic [31:0] nm [NE];
      logic [31:0] e  [NP];
      logic [AW-1:0] a;
      nm = mm;
      if (clr_left == 0 && wr_en && wr_addr < NE) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) nm[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
         end
      end
      for (int p = 0; p < NP; p++) begin
         a = (p == 0) ? ra0 : ra1;
         e[p] = (clr_left > 0 || a >= NE) ? CV : nm[a];
      end
      if (clr_left > 0) begin
         nm[NE - clr_left] = CV;
         clr_left--;
      end else if (clear_req) begin
         clr_left = NE;
      end
      mm   = nm;
      exp2 = exp1;
      exp1 = e;
   endtask

   // One clock: advance the model, let the edge happen, compare at the falling edge.
   task automatic cycle();
      logic [31:0] e0, e1;
      model_edge();
      @(posedge clk);
      @(negedge clk);
`ifdef BLOCK_RAM_MP_OUTREG_EN
      e0 = exp2[0];
      e1 = exp2[1];
`else
      e0 = exp1[0];
      e1 = exp1[1];
`endif
      chk("model_busy", {31'b0, busy}, {31'b0, clr_left > 0});
      chk("model_rd0", rd_data[31:0], e0);
      chk("model_rd1", rd_data[63:32], e1);
   endtask

   task automatic idle_inputs();
      clear_req = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_be     = '0;
      wr_data   = '0;
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (busy && n < 100) begin
         cycle();
         n++;
      end
      chk(name, 32'(n), 32'(NE));
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] x0;
      logic [31:0] x1;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 5'd5,  4'hF, 32'h11223344, 5'd5,  5'd5,  32'h11223344, 32'h11223344};
      vecs[1] = '{1'b1, 5'd5,  4'h5, 32'hAABBCCDD, 5'd5,  5'd5,  32'h11BB33DD, 32'h11BB33DD};
      vecs[2] = '{1'b1, 5'd7,  4'h3, 32'hCAFEF00D, 5'd7,  5'd8,  32'hDEADF00D, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd30, 4'hF, 32'h12345678, 5'd30, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 5'd9,  4'hF, 32'h00000000, 5'd5,  5'd7,  32'h11BB33DD, 32'hDEADF00D};
      vecs[5] = '{1'b1, 5'd23, 4'h0, 32'h00000000, 5'd23, 5'd23, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 5'd23, 4'h8, 32'h01000000, 5'd23, 5'd22, 32'h01ADBEEF, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 5'd0,  4'h0, 32'h00000000, 5'd0,  5'd23, 32'hDEADBEEF, 32'h01ADBEEF};

      rst_n = 1'b0;
      ra0   = '0;
      ra1   = '0;
      idle_inputs();
      model_reset();
      for (int i = 0; i < NE; i++) mm[i] = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd1);
      chk("reset_rd0", rd_data[31:0], CV);
      chk("reset_rd1", rd_data[63:32], CV);

      rst_n = 1'b1;
      count_busy("init_busy_len");

      ra0 = 5'd0;
      ra1 = 5'd23;
      repeat (Lat) cycle();
      chk("init_rd0_addr0", rd_data[31:0], CV);
      chk("init_rd1_addr23", rd_data[63:32], CV);

      foreach (vecs[i]) begin
         wr_en   = vecs[i].we;
         wr_addr = vecs[i].wa;
         wr_be   = vecs[i].be;
         wr_data = vecs[i].wd;
         ra0     = vecs[i].r0;
         ra1     = vecs[i].r1;
         cycle();
         wr_en = 1'b0;
         repeat (Lat - 1) cycle();
         chk($sformatf("vec%0d_rd0", i), rd_data[31:0], vecs[i].x0);
         chk($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].x1);
      end

      // Write and clear request together, then writes and a second request during CLEAR.
      wr_en     = 1'b1;
      wr_addr   = 5'd3;
      wr_be     = 4'hF;
      wr_data   = 32'h55555555;
      clear_req = 1'b1;
      cycle();
      begin
         int n = 0;
         while (busy && n < 100) begin
            wr_en     = 1'b1;
            wr_addr   = 5'(n % NE);
            wr_be     = 4'hF;
            wr_data   = 32'h0BAD0000 + n;
            clear_req = (n == 10);
            cycle();
            n++;
         end
         chk("reclear_busy_len", 32'(n), 32'(NE));
      end
      idle_inputs();
      for (int a = 0; a < NE; a++) begin
         ra0 = 5'(a);
         ra1 = 5'(NE - 1 - a);
         repeat (Lat) cycle();
         chk($sformatf("cleared_rd0_a%0d", a), rd_data[31:0], CV);
         chk($sformatf("cleared_rd1_a%0d", NE - 1 - a), rd_data[63:32], CV);
      end

      // Reset asserted partway through a clear restarts the full sequence.
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      repeat (12) cycle();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_busy", {31'b0, busy}, 32'd1);
      chk("midrst_rd0", rd_data[31:0], CV);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("midrst_busy_len");

      for (int i = 0; i < 400; i++) begin
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_addr   = 5'($urandom_range(0, 31));
         wr_be     = 4'($urandom_range(0, 15));
         wr_data   = $urandom;
         ra0       = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         ra1       = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         clear_req = ($urandom_range(0, 59) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
